prbs_pattern_engine: RTL and testbench

Parametrised successor to the single-channel PRBS generator path. It combines a phase-accumulator bit-rate NCO, a polynomial-selectable LFSR (PN7 to PN31), one-shot bit-error injection, programmable high/low levels and slew-limited edges into one DAC_W-wide sample stream. It sits between the channel register block and the DAC output mux, and runs entirely in the DAC clock domain.

---
 rtl/prbs_pkg.sv | 49 ++++
 rtl/prbs_slew_ramp.sv | 52 +++++
 rtl/prbs_pattern_engine.sv | 158 +++++++++++++++
 tb/tb_prbs_pattern_engine.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - PN codes, LFSR tap table and FSM states for the PRBS pattern engine
package prbs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        RUN  = 2'd2
    } prbs_state_e;

    localparam logic [2:0] PN7_CODE  = 3'd0;
    localparam logic [2:0] PN9_CODE  = 3'd1;
    localparam logic [2:0] PN15_CODE = 3'd2;
    localparam logic [2:0] PN23_CODE = 3'd3;
    localparam logic [2:0] PN31_CODE = 3'd4;

    // Fibonacci taps (a,b): feedback = s[a-1] ^ s[b-1]; a is also the active width
    localparam logic [5:0] PN7_TAP_A  = 6'd7;
    localparam logic [5:0] PN7_TAP_B  = 6'd6;
    localparam logic [5:0] PN9_TAP_A  = 6'd9;
    localparam logic [5:0] PN9_TAP_B  = 6'd5;
    localparam logic [5:0] PN15_TAP_A = 6'd15;
    localparam logic [5:0] PN15_TAP_B = 6'd14;
    localparam logic [5:0] PN23_TAP_A = 6'd23;
    localparam logic [5:0] PN23_TAP_B = 6'd18;
    localparam logic [5:0] PN31_TAP_A = 6'd31;
    localparam logic [5:0] PN31_TAP_B = 6'd28;

    // Unused codes 5-7 fall back to PN7
    function automatic logic [5:0] pn_tap_a(input logic [2:0] code);
        case (code)
            PN9_CODE:  return PN9_TAP_A;
            PN15_CODE: return PN15_TAP_A;
            PN23_CODE: return PN23_TAP_A;
            PN31_CODE: return PN31_TAP_A;
            default:   return PN7_TAP_A;
        endcase
    endfunction

    function automatic logic [5:0] pn_tap_b(input logic [2:0] code);
        case (code)
            PN9_CODE:  return PN9_TAP_B;
            PN15_CODE: return PN15_TAP_B;
            PN23_CODE: return PN23_TAP_B;
            PN31_CODE: return PN31_TAP_B;
            default:   return PN7_TAP_B;
        endcase
    endfunction

endpackage

// File: rtl/prbs_slew_ramp.sv
// rtl/prbs_slew_ramp.sv - saturating slew-limited ramp toward a target code
module prbs_slew_ramp #(
    parameter int DAC_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DAC_W-1:0] target,
    input  logic [DAC_W-1:0] rate,
    output logic [DAC_W-1:0] ramp
);

    // ramp_q is the value reached so far; ramp is the value it steps to this cycle
    logic [DAC_W-1:0] ramp_q;
    logic [DAC_W:0]   cur;
    logic [DAC_W:0]   tgt;
    logic [DAC_W:0]   step;
    logic [DAC_W:0]   rise;
    logic [DAC_W:0]   gap;

    // One step toward target, landing exactly on it when the step would reach or pass it
    always_comb begin
        cur  = {1'b0, ramp_q};
        tgt  = {1'b0, target};
        step = {1'b0, rate};
        rise = cur + step;
        gap  = cur - tgt;
        ramp = ramp_q;
        if (cur < tgt) begin
            if ((rate == '0) || (rise >= tgt)) begin
                ramp = target;
            end else begin
                ramp = rise[DAC_W-1:0];
            end
        end else if (cur > tgt) begin
            if ((rate == '0) || (step >= gap)) begin
                ramp = target;
            end else begin
                ramp = ramp_q - rate;
            end
        end
    end

    // Ramp state register
    always_ff @(posedge clk) begin
        if (reset) begin
            ramp_q <= '0;
        end else begin
            ramp_q <= ramp;
        end
    end

endmodule

// File: rtl/prbs_pattern_engine.sv
// rtl/prbs_pattern_engine.sv - NCO-paced selectable PRBS with error injection and shaped DAC output
module prbs_pattern_engine
    import prbs_pkg::*;
#(
    parameter int DAC_W  = 16,
    parameter int ACC_W  = 32,
    parameter int LFSR_W = 31
) (
    input  logic              dac_clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [2:0]        pn_select,
    input  logic [ACC_W-1:0]  bit_rate_step,
    input  logic [DAC_W-1:0]  edge_rate,
    input  logic [DAC_W-1:0]  level_high,
    input  logic [DAC_W-1:0]  level_low,
    input  logic              err_inject,
    input  logic              protect,
    output logic [DAC_W-1:0]  dac_data,
    output logic              bit_out,
    output logic              bit_tick,
    output logic              valid,
    output logic              err_pending,
    output logic [LFSR_W-1:0] lfsr_state
);

    localparam int IDX_W = $clog2(LFSR_W);

    prbs_state_e       state_q;
    prbs_state_e       state_d;
    logic [2:0]        pn_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W:0]    acc_sum;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_shift;
    logic [LFSR_W-1:0] run_mask;
    logic [LFSR_W-1:0] seed_mask;
    logic [5:0]        run_tap_a;
    logic [5:0]        run_tap_b;
    logic [5:0]        seed_tap_a;
    logic              fb;
    logic              carry;
    logic              tick;
    logic              inject;
    logic              bit_out_q;
    logic              bit_tick_q;
    logic              valid_q;
    logic              err_pending_q;
    logic [DAC_W-1:0]  dac_q;
    logic [DAC_W-1:0]  ramp_target;
    logic [DAC_W-1:0]  ramp_next;

    // Tap selection, feedback, NCO carry and the tick/injection qualifiers
    always_comb begin
        run_tap_a  = pn_tap_a(pn_q);
        run_tap_b  = pn_tap_b(pn_q);
        seed_tap_a = pn_tap_a(pn_select);
        run_mask   = LFSR_W'((64'd1 << run_tap_a) - 64'd1);
        seed_mask  = LFSR_W'((64'd1 << seed_tap_a) - 64'd1);
        fb         = lfsr_q[IDX_W'(run_tap_a - 6'd1)] ^ lfsr_q[IDX_W'(run_tap_b - 6'd1)];
        lfsr_shift = {lfsr_q[LFSR_W-2:0], fb} & run_mask;
        acc_sum    = {1'b0, acc_q} + {1'b0, bit_rate_step};
        carry      = acc_sum[ACC_W];
        tick       = (state_q == RUN) && enable && carry;
        inject     = err_pending_q || err_inject;
    end

    // Next-state logic: SEED lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = SEED;
            SEED:    state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, NCO, LFSR and emitted-bit registers
    always_ff @(posedge dac_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pn_q          <= PN7_CODE;
            acc_q         <= '0;
            lfsr_q        <= '1;
            bit_out_q     <= 1'b0;
            bit_tick_q    <= 1'b0;
            valid_q       <= 1'b0;
            err_pending_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (tick) begin
                err_pending_q <= 1'b0;
            end else if (err_inject) begin
                err_pending_q <= 1'b1;
            end
            case (state_q)
                SEED: begin
                    pn_q       <= pn_select;
                    lfsr_q     <= seed_mask;
                    acc_q      <= '0;
                    bit_out_q  <= 1'b0;
                    bit_tick_q <= 1'b0;
                    valid_q    <= 1'b0;
                end
                RUN: begin
                    if (enable) begin
                        acc_q      <= acc_sum[ACC_W-1:0];
                        bit_tick_q <= carry;
                        if (carry) begin
                            lfsr_q    <= lfsr_shift;
                            bit_out_q <= fb ^ inject;
                            valid_q   <= 1'b1;
                        end
                    end else begin
                        bit_out_q  <= 1'b0;
                        bit_tick_q <= 1'b0;
                        valid_q    <= 1'b0;
                    end
                end
                default: begin
                    bit_out_q  <= 1'b0;
                    bit_tick_q <= 1'b0;
                    valid_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ramp_target = bit_out_q ? level_high : level_low;

    prbs_slew_ramp #(
        .DAC_W (DAC_W)
    ) u_ramp (
        .clk    (dac_clk),
        .reset  (reset),
        .target (ramp_target),
        .rate   (edge_rate),
        .ramp   (ramp_next)
    );

    // Output register; protect blanks the output while the ramp keeps tracking
    always_ff @(posedge dac_clk) begin
        if (reset) begin
            dac_q <= '0;
        end else begin
            dac_q <= protect ? '0 : ramp_next;
        end
    end

    assign dac_data    = dac_q;
    assign bit_out     = bit_out_q;
    assign bit_tick    = bit_tick_q;
    assign valid       = valid_q;
    assign err_pending = err_pending_q;
    assign lfsr_state  = lfsr_q;

endmodule

// File: tb/tb_prbs_pattern_engine.sv
// tb/tb_prbs_pattern_engine.sv - directed self-checking bench for prbs_pattern_engine
module tb_prbs_pattern_engine;

    logic        dac_clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  pn_select;
    logic [31:0] bit_rate_step;
    logic [15:0] edge_rate;
    logic [15:0] level_high;
    logic [15:0] level_low;
    logic        err_inject;
    logic        protect;
    logic [15:0] dac_data;
    logic        bit_out;
    logic        bit_tick;
    logic        valid;
    logic        err_pending;
    logic [30:0] lfsr_state;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [30:0] m_state;
    logic [2:0]  m_pn;

    prbs_pattern_engine dut (
        .dac_clk       (dac_clk),
        .reset         (reset),
        .enable        (enable),
        .pn_select     (pn_select),
        .bit_rate_step (bit_rate_step),
        .edge_rate     (edge_rate),
        .level_high    (level_high),
        .level_low     (level_low),
        .err_inject    (err_inject),
        .protect       (protect),
        .dac_data      (dac_data),
        .bit_out       (bit_out),
        .bit_tick      (bit_tick),
        .valid         (valid),
        .err_pending   (err_pending),
        .lfsr_state    (lfsr_state)
    );

    always #5 dac_clk = ~dac_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge dac_clk);
        #1;
    endtask

    function automatic int tap_a(input logic [2:0] pn);
        case (pn)
            3'd1: return 9;
            3'd2: return 15;
            3'd3: return 23;
            3'd4: return 31;
            default: return 7;
        endcase
    endfunction

    function automatic int tap_b(input logic [2:0] pn);
        case (pn)
            3'd1: return 5;
            3'd2: return 14;
            3'd3: return 18;
            3'd4: return 28;
            default: return 6;
        endcase
    endfunction

    task automatic model_seed(input logic [2:0] pn);
        m_pn    = pn;
        m_state = '0;
        for (int i = 0; i < tap_a(pn); i++) m_state[i] = 1'b1;
    endtask

    task automatic model_tick(output logic b);
        int a;
        int bb;
        a  = tap_a(m_pn);
        bb = tap_b(m_pn);
        b  = m_state[a-1] ^ m_state[bb-1];
        m_state = {m_state[29:0], b};
        for (int i = a; i < 31; i++) m_state[i] = 1'b0;
    endtask

    task automatic wait_tick(output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < 200) begin
            step();
            cyc++;
            ok = bit_tick;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        err_inject = 1'b0;
        protect    = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        level_low = 16'h1000; level_high = 16'hF000; edge_rate = 16'h0000;
        bit_rate_step = 32'h8000_0000; pn_select = 3'd0;
        reset = 1'b1; enable = 1'b1; err_inject = 1'b1; protect = 1'b0;
        step(); step(); step();
        n_cmp++; if (dac_data !== 16'h0000) begin n_err++; $display("FAIL reset_dac got %h exp 0000", dac_data); end
        n_cmp++; if (bit_out !== 1'b0) begin n_err++; $display("FAIL reset_bit_out got %b exp 0", bit_out); end
        n_cmp++; if (bit_tick !== 1'b0) begin n_err++; $display("FAIL reset_bit_tick got %b exp 0", bit_tick); end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", valid); end
        n_cmp++; if (err_pending !== 1'b0) begin n_err++; $display("FAIL reset_err_pending got %b exp 0", err_pending); end
        err_inject = 1'b0; enable = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_pn7_sequence();
        logic bits [0:299];
        logic e;
        logic prev;
        bit   early;
        int   cyc;
        int   n;
        int   last;
        level_low = 16'h1000; level_high = 16'hF000; edge_rate = 16'h0000;
        bit_rate_step = 32'h8000_0000; pn_select = 3'd0;
        do_reset();
        enable = 1'b1;
        model_seed(3'd0);
        early = 1'b0; cyc = 0;
        while (!bit_tick && cyc < 20) begin
            if (valid) early = 1'b1;
            step();
            cyc++;
        end
        n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL pn7_first_tick_latency got %0d exp 4", cyc); end
        n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL pn7_valid_early got %b exp 0", early); end
        n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL pn7_valid_at_first_tick got %b exp 1", valid); end
        prev = 1'b0; n = 0; last = 0;
        for (int c = 0; c < 520; c++) begin
            if (bit_tick) begin
                model_tick(e);
                n_cmp++; if (bit_out !== e) begin n_err++; $display("FAIL pn7_bit[%0d] got %b exp %b", n, bit_out, e); end
                n_cmp++; if (lfsr_state !== m_state) begin n_err++; $display("FAIL pn7_lfsr[%0d] got %h exp %h", n, lfsr_state, m_state); end
                if (n > 0) begin
                    n_cmp++; if (c - last !== 2) begin n_err++; $display("FAIL pn7_tick_spacing got %0d exp 2", c - last); end
                end
                last = c;
                if (n < 300) bits[n] = bit_out;
                n++;
            end
            n_cmp++; if (dac_data !== (prev ? 16'hF000 : 16'h1000)) begin n_err++; $display("FAIL pn7_dac_jump cycle %0d got %h exp %h", c, dac_data, prev ? 16'hF000 : 16'h1000); end
            prev = bit_out;
            step();
        end
        n_cmp++; if (n !== 260) begin n_err++; $display("FAIL pn7_tick_count got %0d exp 260", n); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (bits[i] !== 1'b0) begin n_err++; $display("FAIL pn7_leading_zero[%0d] got %b exp 0", i, bits[i]); end
        end
        n_cmp++; if (bits[6] !== 1'b1) begin n_err++; $display("FAIL pn7_seventh_bit got %b exp 1", bits[6]); end
        for (int i = 0; i < 127; i++) begin
            n_cmp++; if (bits[i] !== bits[i+127]) begin n_err++; $display("FAIL pn7_period[%0d] got %b exp %b", i, bits[i+127], bits[i]); end
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_pn31_and_select_latch();
        logic e;
        bit   ok;
        int   cyc;
        edge_rate = 16'h0000; bit_rate_step = 32'hFFFF_FFFF; pn_select = 3'd4;
        do_reset();
        enable = 1'b1;
        model_seed(3'd4);
        wait_tick(ok, cyc);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL pn31_first_tick got timeout exp tick"); end
        for (int i = 0; i < 10000; i++) begin
            n_cmp++; if (bit_tick !== 1'b1) begin n_err++; $display("FAIL pn31_tick[%0d] got %b exp 1", i, bit_tick); end
            model_tick(e);
            n_cmp++; if (bit_out !== e) begin n_err++; $display("FAIL pn31_bit[%0d] got %b exp %b", i, bit_out, e); end
            n_cmp++; if (lfsr_state !== m_state) begin n_err++; $display("FAIL pn31_lfsr[%0d] got %h exp %h", i, lfsr_state, m_state); end
            if (i == 5000) pn_select = 3'd0;
            step();
        end
        enable = 1'b0;
        step();
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL pn31_valid_after_drop got %b exp 0", valid); end
        step();
        enable = 1'b1;
        model_seed(3'd0);
        for (int i = 0; i < 20; i++) begin
            wait_tick(ok, cyc);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL reseed_tick[%0d] got timeout exp tick", i); end
            model_tick(e);
            n_cmp++; if (bit_out !== e) begin n_err++; $display("FAIL reseed_pn7_bit[%0d] got %b exp %b", i, bit_out, e); end
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_ramp();
        logic [15:0] fall_exp [0:5];
        logic [15:0] ret_exp [0:5];
        logic [15:0] exp;
        bit   ok;
        int   cyc;
        int   t;
        fall_exp = '{16'hC000, 16'h9000, 16'h6000, 16'h3000, 16'h1000, 16'h1000};
        ret_exp  = '{16'h2000, 16'h3000, 16'h4000, 16'h3000, 16'h2000, 16'h2000};
        level_low = 16'h1000; level_high = 16'hF000; edge_rate = 16'h1000;
        bit_rate_step = 32'h0800_0000; pn_select = 3'd0;
        do_reset();
        enable = 1'b1;
        t = 0; ok = 1'b1;
        while (ok && !(bit_tick && bit_out) && t < 10) begin
            wait_tick(ok, cyc);
            t++;
        end
        n_cmp++; if (t !== 7) begin n_err++; $display("FAIL ramp_first_one_tick got %0d exp 7", t); end
        n_cmp++; if (dac_data !== 16'h1000) begin n_err++; $display("FAIL ramp_start got %h exp 1000", dac_data); end
        for (int k = 1; k < 32; k++) begin
            step();
            exp = (k <= 14) ? 16'(16'h1000 + k * 16'h1000) : 16'hF000;
            n_cmp++; if (dac_data !== exp) begin n_err++; $display("FAIL ramp_rise[%0d] got %h exp %h", k, dac_data, exp); end
        end
        edge_rate = 16'h3000;
        step();
        n_cmp++; if (bit_tick !== 1'b1 || bit_out !== 1'b0) begin n_err++; $display("FAIL ramp_eighth_bit got tick %b bit %b exp tick 1 bit 0", bit_tick, bit_out); end
        n_cmp++; if (dac_data !== 16'hF000) begin n_err++; $display("FAIL ramp_fall_start got %h exp f000", dac_data); end
        for (int j = 0; j < 6; j++) begin
            step();
            n_cmp++; if (dac_data !== fall_exp[j]) begin n_err++; $display("FAIL ramp_fall[%0d] got %h exp %h", j, dac_data, fall_exp[j]); end
        end
        edge_rate = 16'h1000;
        level_low = 16'h8000;
        for (int j = 0; j < 6; j++) begin
            step();
            n_cmp++; if (dac_data !== ret_exp[j]) begin n_err++; $display("FAIL ramp_retarget[%0d] got %h exp %h", j, dac_data, ret_exp[j]); end
            if (j == 2) level_low = 16'h2000;
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_err_inject();
        logic e;
        logic inv;
        bit   ok;
        int   cyc;
        level_low = 16'h1000; level_high = 16'hF000; edge_rate = 16'h0000;
        bit_rate_step = 32'h8000_0000; pn_select = 3'd0;
        do_reset();
        enable = 1'b1;
        model_seed(3'd0);
        wait_tick(ok, cyc);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL err_first_tick got timeout exp tick"); end
        model_tick(e);
        n_cmp++; if (bit_out !== e) begin n_err++; $display("FAIL err_bit[0] got %b exp %b", bit_out, e); end
        for (int i = 1; i < 40; i++) begin
            inv = 1'b0;
            if (i == 10) begin
                err_inject = 1'b1; step(); err_inject = 1'b0;
                n_cmp++; if (err_pending !== 1'b1) begin n_err++; $display("FAIL err_pending_set got %b exp 1", err_pending); end
                step(); inv = 1'b1;
            end else if (i == 20) begin
                step(); err_inject = 1'b1; step(); err_inject = 1'b0; inv = 1'b1;
            end else if (i == 30) begin
                err_inject = 1'b1; step();
                n_cmp++; if (err_pending !== 1'b1) begin n_err++; $display("FAIL err_pending_rearm got %b exp 1", err_pending); end
                step(); err_inject = 1'b0; inv = 1'b1;
            end else begin
                step(); step();
            end
            n_cmp++; if (bit_tick !== 1'b1) begin n_err++; $display("FAIL err_tick[%0d] got %b exp 1", i, bit_tick); end
            model_tick(e);
            n_cmp++; if (bit_out !== (e ^ inv)) begin n_err++; $display("FAIL err_bit[%0d] got %b exp %b", i, bit_out, e ^ inv); end
            n_cmp++; if (err_pending !== 1'b0) begin n_err++; $display("FAIL err_pending_clear[%0d] got %b exp 0", i, err_pending); end
            n_cmp++; if (lfsr_state !== m_state) begin n_err++; $display("FAIL err_lfsr[%0d] got %h exp %h", i, lfsr_state, m_state); end
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_protect();
        logic e;
        logic rec;
        bit   ok;
        int   cyc;
        level_low = 16'h1000; level_high = 16'hF000; edge_rate = 16'h0000;
        bit_rate_step = 32'h8000_0000; pn_select = 3'd0;
        do_reset();
        enable = 1'b1;
        model_seed(3'd0);
        for (int i = 0; i < 6; i++) begin
            wait_tick(ok, cyc);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL prot_pre_tick[%0d] got timeout exp tick", i); end
            model_tick(e);
            n_cmp++; if (bit_out !== e) begin n_err++; $display("FAIL prot_pre_bit[%0d] got %b exp %b", i, bit_out, e); end
        end
        protect = 1'b1;
        for (int c = 0; c < 50; c++) begin
            step();
            n_cmp++; if (dac_data !== 16'h0000) begin n_err++; $display("FAIL prot_dac_zero[%0d] got %h exp 0000", c, dac_data); end
            if (bit_tick) begin
                model_tick(e);
                n_cmp++; if (bit_out !== e) begin n_err++; $display("FAIL prot_bit_during[%0d] got %b exp %b", c, bit_out, e); end
            end
        end
        protect = 1'b0;
        rec = bit_out;
        step();
        n_cmp++; if (dac_data !== (rec ? 16'hF000 : 16'h1000)) begin n_err++; $display("FAIL prot_release_dac got %h exp %h", dac_data, rec ? 16'hF000 : 16'h1000); end
        if (bit_tick) begin
            model_tick(e);
            n_cmp++; if (bit_out !== e) begin n_err++; $display("FAIL prot_release_bit got %b exp %b", bit_out, e); end
        end
        for (int i = 0; i < 20; i++) begin
            wait_tick(ok, cyc);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL prot_post_tick[%0d] got timeout exp tick", i); end
            model_tick(e);
            n_cmp++; if (bit_out !== e) begin n_err++; $display("FAIL prot_post_bit[%0d] got %b exp %b", i, bit_out, e); end
        end
        enable = 1'b0;
        step();
    endtask

    task automatic test_enable_drop_and_reset();
        logic [15:0] drop_exp [0:7];
        bit   ok;
        int   cyc;
        int   t;
        drop_exp = '{16'h7000, 16'h6000, 16'h5000, 16'h4000, 16'h3000, 16'h2000, 16'h1000, 16'h1000};
        level_low = 16'h1000; level_high = 16'hF000; edge_rate = 16'h1000;
        bit_rate_step = 32'h0800_0000; pn_select = 3'd0;
        do_reset();
        enable = 1'b1;
        t = 0; ok = 1'b1;
        while (ok && !(bit_tick && bit_out) && t < 10) begin
            wait_tick(ok, cyc);
            t++;
        end
        n_cmp++; if (!(bit_tick && bit_out)) begin n_err++; $display("FAIL drop_find_one got tick %b bit %b exp 1 1", bit_tick, bit_out); end
        for (int k = 0; k < 5; k++) step();
        n_cmp++; if (dac_data !== 16'h6000) begin n_err++; $display("FAIL drop_mid_ramp got %h exp 6000", dac_data); end
        enable = 1'b0;
        step();
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL drop_valid got %b exp 0", valid); end
        n_cmp++; if (bit_out !== 1'b0 || bit_tick !== 1'b0) begin n_err++; $display("FAIL drop_bit got bit %b tick %b exp 0 0", bit_out, bit_tick); end
        n_cmp++; if (dac_data !== drop_exp[0]) begin n_err++; $display("FAIL drop_ramp[0] got %h exp %h", dac_data, drop_exp[0]); end
        for (int j = 1; j < 8; j++) begin
            step();
            n_cmp++; if (dac_data !== drop_exp[j]) begin n_err++; $display("FAIL drop_ramp[%0d] got %h exp %h", j, dac_data, drop_exp[j]); end
        end
        enable = 1'b1;
        t = 0; ok = 1'b1;
        while (ok && !(bit_tick && bit_out) && t < 10) begin
            wait_tick(ok, cyc);
            t++;
        end
        n_cmp++; if (!(bit_tick && bit_out)) begin n_err++; $display("FAIL rst_find_one got tick %b bit %b exp 1 1", bit_tick, bit_out); end
        step(); step();
        err_inject = 1'b1;
        step();
        err_inject = 1'b0;
        n_cmp++; if (dac_data !== 16'h4000) begin n_err++; $display("FAIL rst_mid_ramp got %h exp 4000", dac_data); end
        n_cmp++; if (err_pending !== 1'b1) begin n_err++; $display("FAIL rst_pending_armed got %b exp 1", err_pending); end
        reset = 1'b1;
        step();
        n_cmp++; if (dac_data !== 16'h0000) begin n_err++; $display("FAIL rst_dac got %h exp 0000", dac_data); end
        n_cmp++; if (bit_out !== 1'b0 || bit_tick !== 1'b0) begin n_err++; $display("FAIL rst_bit got bit %b tick %b exp 0 0", bit_out, bit_tick); end
        n_cmp++; if (valid !== 1'b0 || err_pending !== 1'b0) begin n_err++; $display("FAIL rst_flags got valid %b pending %b exp 0 0", valid, err_pending); end
        reset = 1'b0;
        enable = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; pn_select = 3'd0; bit_rate_step = '0;
        edge_rate = '0; level_high = '0; level_low = '0; err_inject = 1'b0; protect = 1'b0;
        test_reset();
        test_pn7_sequence();
        test_pn31_and_select_latch();
        test_ramp();
        test_err_inject();
        test_protect();
        test_enable_drop_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
